mult_seq_ctrl: RTL and testbench

- Sequencer for the board's shift-add multiplier datapath.
- Captures two unsigned operands on a start pulse and runs one partial-product step per clock through an internal accumulator.
- Raises a one-cycle done pulse and holds the registered product for the display/output logic.
- Sits between the switch/button input flops and the product display path on the 100 MHz domain.

---
 rtl/mult_seq_ctrl.sv | 117 +++++++++++
 tb/tb_mult_seq_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl: sequencer for the shift-add multiplier datapath.
// Captures two unsigned operands on start, runs one partial-product step per
// clock, then pulses done for one cycle and holds the registered product.
// Optional build macro: MULT_SEQ_EARLY_TERM_EN (finish as soon as the
// remaining multiplier bits are all zero).
module mult_seq_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clock_100Mhz,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW     = 2 * WIDTH;
  localparam int unsigned STEP_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic                busy_nxt;
  logic                done_nxt;

  logic [PW-1:0]       mcand_r;
  logic [WIDTH-1:0]    mplr_r;
  logic [PW-1:0]       acc;
  logic [STEP_W-1:0]   step;

  logic [PW-1:0]       acc_step_c;
  logic [WIDTH-1:0]    mplr_shift_c;
  logic                last_step_c;

  // Partial-product step and end-of-run detection for the current RUN cycle
  always_comb begin
    acc_step_c   = acc;
    mplr_shift_c = mplr_r >> 1;
    if (mplr_r[0]) begin
      acc_step_c = acc + (mcand_r << step);
    end
`ifdef MULT_SEQ_EARLY_TERM_EN
    last_step_c = (step == STEP_W'(WIDTH - 1)) || (mplr_shift_c == '0);
`else
    last_step_c = (step == STEP_W'(WIDTH - 1));
`endif
  end

  // State register plus registered status flags
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      busy  <= busy_nxt;
      done  <= done_nxt;
    end
  end

  // Next-state logic; illegal encodings fall back to IDLE
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = start ? S_RUN : S_IDLE;
      S_RUN:   state_nxt = last_step_c ? S_DONE : S_RUN;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Status flags follow the state being entered so they line up with it
  always_comb begin
    busy_nxt = 1'b0;
    done_nxt = 1'b0;
    if (state_nxt == S_RUN) begin
      busy_nxt = 1'b1;
    end
    if (state_nxt == S_DONE) begin
      done_nxt = 1'b1;
    end
  end

  // Operand capture, accumulation and product load
  always_ff @(posedge clock_100Mhz or negedge reset) begin
    if (!reset) begin
      mcand_r <= '0;
      mplr_r  <= '0;
      acc     <= '0;
      step    <= '0;
      product <= '0;
    end else begin
      if (state == S_IDLE && start) begin
        mcand_r <= PW'(multiplicand);
        mplr_r  <= multiplier;
        acc     <= '0;
        step    <= '0;
      end else if (state == S_RUN) begin
        acc    <= acc_step_c;
        mplr_r <= mplr_shift_c;
        step   <= step + STEP_W'(1);
        if (last_step_c) begin
          product <= acc_step_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// tb_mult_seq_ctrl: table-driven operations with a product scoreboard, plus
// hand-written sequences for start-ignore, mid-run reset and held start.
module tb_mult_seq_ctrl;

  localparam int unsigned W = 4;

  logic           clock_100Mhz = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   multiplicand;
  logic [W-1:0]   multiplier;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int total = 0;
  int bad   = 0;

  logic [2*W-1:0] sb[$];

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [2*W-1:0] p;
  } vec_t;

  vec_t vecs[9];

  mult_seq_ctrl #(.WIDTH(W)) dut (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clock_100Mhz = ~clock_100Mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected number of RUN cycles for a given multiplier
  function automatic int exp_runs(input logic [W-1:0] b);
    int r;
`ifdef MULT_SEQ_EARLY_TERM_EN
    r = 1;
    for (int i = 0; i < int'(W); i++) begin
      if (b[i]) r = i + 1;
    end
`else
    r = int'(W);
`endif
    return r;
  endfunction

  // One full operation: start, count RUN cycles, check done/product/hold
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2*W-1:0] p);
    int runs;
    bit seen;
    @(negedge clock_100Mhz);
    start = 1'b1; multiplicand = a; multiplier = b;
    sb.push_back(p);
    @(negedge clock_100Mhz);
    start = 1'b0; multiplicand = ~a; multiplier = ~b;
    runs = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (done) seen = 1'b1;
      else begin
        if (busy) runs++;
        @(negedge clock_100Mhz);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("run_cycles", 32'(runs), 32'(exp_runs(b)));
    chk("busy_in_done", 32'(busy), 32'd0);
    if (sb.size() > 0) chk("product", 32'(product), 32'(sb.pop_front()));
    else begin
      total++; bad++;
      $display("FAIL scoreboard: empty queue at %0t", $time);
    end
    @(negedge clock_100Mhz);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("product_hold", 32'(product), 32'(p));
  endtask

  initial begin
    int dones;
    int last_done;
    int cyc;
    logic bad_prod;

    vecs[0] = '{a: 4'hF, b: 4'hF, p: 8'hE1};
    vecs[1] = '{a: 4'h7, b: 4'h0, p: 8'h00};
    vecs[2] = '{a: 4'h0, b: 4'h9, p: 8'h00};
    vecs[3] = '{a: 4'h3, b: 4'h5, p: 8'h0F};
    vecs[4] = '{a: 4'hA, b: 4'h2, p: 8'h14};
    vecs[5] = '{a: 4'h1, b: 4'h1, p: 8'h01};
    vecs[6] = '{a: 4'hF, b: 4'h1, p: 8'h0F};
    vecs[7] = '{a: 4'h8, b: 4'h8, p: 8'h40};
    vecs[8] = '{a: 4'hC, b: 4'hB, p: 8'h84};

    reset = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    #3;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_product", 32'(product), 32'd0);
    repeat (2) @(negedge clock_100Mhz);
    reset = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].p);
    end

    // Start pulses during RUN are ignored; exactly one completion
    @(negedge clock_100Mhz);
    start = 1'b1; multiplicand = 4'h3; multiplier = 4'h5;
    @(negedge clock_100Mhz);
    multiplicand = 4'hF; multiplier = 4'hF;
    @(negedge clock_100Mhz);
    dones = done ? 1 : 0;
    @(negedge clock_100Mhz);
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (done) dones++;
      @(negedge clock_100Mhz);
    end
    chk("ignore_done_count", 32'(dones), 32'd1);
    chk("ignore_product", 32'(product), 32'h0F);

    // Reset mid-run clears everything and produces no completion
    @(negedge clock_100Mhz);
    start = 1'b1; multiplicand = 4'h9; multiplier = 4'h6;
    @(negedge clock_100Mhz);
    start = 1'b0;
    @(negedge clock_100Mhz);
    chk("midrun_busy_before", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrun_reset_busy", 32'(busy), 32'd0);
    chk("midrun_reset_done", 32'(done), 32'd0);
    chk("midrun_reset_product", 32'(product), 32'd0);
    @(negedge clock_100Mhz);
    reset = 1'b1;
    dones = 0;
    for (int i = 0; i < 10; i++) begin
      if (done || busy) dones++;
      @(negedge clock_100Mhz);
    end
    chk("after_reset_idle", 32'(dones), 32'd0);
    chk("after_reset_product", 32'(product), 32'd0);

    // Start held high: back-to-back operations every RUN+2 cycles
    start = 1'b1; multiplicand = 4'h2; multiplier = 4'h3;
    dones = 0; last_done = -1; bad_prod = 1'b0;
    for (cyc = 0; cyc < 30; cyc++) begin
      @(negedge clock_100Mhz);
      if (done) begin
        if (product !== 8'h06) bad_prod = 1'b1;
        if (last_done >= 0) chk("held_period", 32'(cyc - last_done), 32'(exp_runs(4'h3) + 2));
        last_done = cyc;
        dones++;
      end
    end
    start = 1'b0;
    chk("held_product", 32'(bad_prod), 32'd0);
    chk("held_done_count_min", 32'(dones >= 4), 32'd1);

    // Normal operation still works afterwards
    repeat (W + 3) @(negedge clock_100Mhz);
    run_op(4'h5, 4'h7, 8'h23);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout");
    $fatal(1, "timeout");
  end

endmodule
